// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch stage and the M stage onto one memory port.
// Each access waits for mem_ready_i or times out. A timeout raises a bus-error pulse toward the trap logic.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        if_flush_i,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_be_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic        dm_gnt_o,
  output logic        dm_rvalid_o,
  output logic [31:0] dm_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic        bus_err_o,
  output logic        bus_err_dm_o,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a request is held by the requester until its grant is seen.
  // The grant is combinational and only asserts in IDLE. The rvalid that
  // follows is a one-cycle registered pulse, one cycle after mem_ready_i.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [3:0]  streak_q, streak_d;
  logic        drop_q, drop_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        dm_rvalid_q, dm_rvalid_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        bus_err_q, bus_err_d;
  logic        bus_err_dm_q, bus_err_dm_d;

  logic if_pend;
  logic starve;
  logic timed_out;
  logic fetch_dropped;

  assign if_pend       = if_req_i & ~if_flush_i;
  assign starve        = (streak_q == 4'(STARVE_LIM)) & if_pend;
  assign timed_out     = (wait_cnt_q == 8'(TIMEOUT - 1));
  assign fetch_dropped = drop_q | if_flush_i;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    streak_d     = streak_q;
    drop_d       = drop_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rvalid_d  = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_rvalid_d  = 1'b0;
    dm_rdata_d   = dm_rdata_q;
    bus_err_d    = 1'b0;
    bus_err_dm_d = 1'b0;
    if_gnt_o     = 1'b0;
    dm_gnt_o     = 1'b0;

    unique case (state_q)
      IDLE: begin
        wait_cnt_d = 8'd0;
        drop_d     = 1'b0;
        // Grants are gated by reset so that every output reads 0 while reset is held.
        if (rst_n_i && dm_req_i && !starve) begin
          dm_gnt_o    = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we_i;
          mem_be_d    = dm_be_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          state_d     = DM_BUSY;
          if (!if_pend) begin
            streak_d = 4'd0;
          end else if (streak_q != 4'(STARVE_LIM)) begin
            streak_d = streak_q + 4'd1;
          end
        end else if (rst_n_i && if_pend) begin
          if_gnt_o   = 1'b1;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_be_d   = 4'hF;
          mem_addr_d = if_addr_i;
          streak_d   = 4'd0;
          state_d    = IF_BUSY;
        end else if (!if_pend) begin
          streak_d = 4'd0;
        end
      end

      IF_BUSY: begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        if (if_flush_i) drop_d = 1'b1;
        if (mem_ready_i) begin
          mem_req_d   = 1'b0;
          if_rvalid_d = ~fetch_dropped;
          if_rdata_d  = mem_rdata_i;
          drop_d      = 1'b0;
          state_d     = IDLE;
        end else if (timed_out) begin
          mem_req_d = 1'b0;
          bus_err_d = ~fetch_dropped;
          drop_d    = 1'b0;
          state_d   = IDLE;
        end
      end

      DM_BUSY: begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        if (mem_ready_i) begin
          mem_req_d   = 1'b0;
          dm_rvalid_d = 1'b1;
          dm_rdata_d  = mem_rdata_i;
          state_d     = IDLE;
        end else if (timed_out) begin
          mem_req_d    = 1'b0;
          bus_err_d    = 1'b1;
          bus_err_dm_d = 1'b1;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      wait_cnt_q   <= 8'd0;
      streak_q     <= 4'd0;
      drop_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'h0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= 32'd0;
      dm_rvalid_q  <= 1'b0;
      dm_rdata_q   <= 32'd0;
      bus_err_q    <= 1'b0;
      bus_err_dm_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      streak_q     <= streak_d;
      drop_q       <= drop_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rvalid_q  <= if_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      dm_rvalid_q  <= dm_rvalid_d;
      dm_rdata_q   <= dm_rdata_d;
      bus_err_q    <= bus_err_d;
      bus_err_dm_q <= bus_err_dm_d;
    end
  end

  assign if_rvalid_o  = if_rvalid_q;
  assign if_rdata_o   = if_rdata_q;
  assign dm_rvalid_o  = dm_rvalid_q;
  assign dm_rdata_o   = dm_rdata_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_be_o     = mem_be_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign bus_err_o    = bus_err_q;
  assign bus_err_dm_o = bus_err_dm_q;
  assign dbg_state_o  = state_q;

endmodule
